booth_mult_arbiter: RTL and testbench

// - Shares one iterative radix-2 Booth multiply datapath among NREQ requesters.
// - Round-robin arbitration; one Booth step per clock; valid/ready on both sides.
// - Sits between requesting engines and the signed-multiply resource.
// - Replaces per-requester combinational multipliers with one sequenced core.

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_step.sv | 35 +++
 rtl/booth_mult_arbiter.sv | 162 ++++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiply arbiter.
// - booth_state_e : top-level FSM states (idle / running / result held)
// - BoothAdd/Sub  : {Q[0], Q_1} codes that select add or subtract of M
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } booth_state_e;

  localparam logic [1:0] BoothAdd = 2'b01;
  localparam logic [1:0] BoothSub = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
// Ports:
//   a_i/a_o     : accumulator in/out, WIDTH+1 bits
//   q_i/q_o     : multiplier register in/out, WIDTH bits
//   q_1_i/q_1_o : extra bit to the right of Q
//   m_i         : sign-extended multiplicand, WIDTH+1 bits
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    case ({q_i[0], q_1_i})
      BoothAdd: sum = a_i + m_i;
      BoothSub: sum = a_i - m_i;
      default:  sum = a_i;
    endcase
    // Arithmetic shift right of {A, Q, Q_1}
    a_o   = {sum[WIDTH], sum[WIDTH:1]};
    q_o   = {sum[0], q_i[WIDTH-1:1]};
    q_1_o = q_i[0];
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one iterative radix-2 Booth multiplier among NREQ requesters.
// Round-robin grant in idle, one Booth step per clock, result held until taken.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid_i       : per-requester operand valid
//   req_ready_o       : per-requester accept, one-hot or zero
//   req_a_i, req_b_i  : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid_o       : product valid
//   rsp_ready_i       : consumer accepts product
//   rsp_product_o     : signed 2*WIDTH product
//   rsp_id_o          : requester index owning rsp_product_o
//   busy_o            : high while running or holding a result
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDW   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [2*WIDTH-1:0]    rsp_product_o,
  output logic [IDW-1:0]        rsp_id_o,
  output logic                  busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  booth_state_e state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;

  logic [WIDTH:0]     a_step;
  logic [WIDTH-1:0]   q_step;
  logic               q1_step;

  logic               grant_valid;
  logic [IDW-1:0]     grant_idx;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .q_1_i (q1_q),
    .m_i   (m_q),
    .a_o   (a_step),
    .q_o   (q_step),
    .q_1_o (q1_step)
  );

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!grant_valid && req_valid_i[(int'(rr_ptr_q) + i) % int'(NREQ)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDW'((int'(rr_ptr_q) + i) % int'(NREQ));
      end
    end
  end

  assign sel_a = req_a_i[int'(grant_idx)*int'(WIDTH) +: WIDTH];
  assign sel_b = req_b_i[int'(grant_idx)*int'(WIDTH) +: WIDTH];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    m_d         = m_q;
    a_d         = a_q;
    q_d         = q_q;
    q1_d        = q1_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    prod_d      = prod_q;
    rsp_id_d    = rsp_id_q;
    req_ready_o = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          // Gated by rst_n so every output reads zero while reset is held.
          req_ready_o[grant_idx] = rst_n;
          m_d      = {sel_a[WIDTH-1], sel_a};
          q_d      = sel_b;
          a_d      = '0;
          q1_d     = 1'b0;
          cnt_d    = CntW'(WIDTH);
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          state_d  = StRun;
        end
      end
      StRun: begin
        a_d   = a_step;
        q_d   = q_step;
        q1_d  = q1_step;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          // A carries one guard bit; the product fits in its low WIDTH bits plus Q.
          prod_d   = {a_step[WIDTH-1:0], q_step};
          rsp_id_d = id_q;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      m_q      <= '0;
      a_q      <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      id_q     <= '0;
      prod_q   <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      m_q      <= m_d;
      a_q      <= a_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      prod_q   <= prod_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid_o   = (state_q == StDone);
  assign busy_o        = (state_q != StIdle);
  assign rsp_product_o = prod_q;
  assign rsp_id_o      = rsp_id_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter (WIDTH=4, NREQ=2).
module tb_booth_mult_arbiter;

  localparam int W   = 4;
  localparam int N   = 2;
  localparam int IDW = 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*W-1:0]   rsp_product;
  logic [IDW-1:0]   rsp_id;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  int rr_model = 0;

  logic signed [W-1:0] op_a [N];
  logic signed [W-1:0] op_b [N];

  always #5 clk = ~clk;

  booth_mult_arbiter #(
    .WIDTH (W),
    .NREQ  (N),
    .IDW   (IDW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_product_o (rsp_product),
    .rsp_id_o      (rsp_id),
    .busy_o        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a,
                                             input logic signed [W-1:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[2*W-1:0];
  endfunction

  function automatic int model_grant(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[(rr_model + i) % N]) return (rr_model + i) % N;
    end
    return -1;
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  endtask

  // Called just after a negedge with the block idle and req_valid already set.
  // stall: extra DONE cycles with rsp_ready low; keep: granted requester re-requests.
  task automatic run_op(input int stall, input bit keep, output int g,
                        output logic [2*W-1:0] prod);
    logic [2*W-1:0] exp_p;
    int lat;
    bit bad;
    pack_ops();
    g = model_grant(req_valid);
    prod = '0;
    if (g < 0) begin
      check_eq("grant_any", 32'(0), 32'(1));
      return;
    end
    #1;
    check_eq("grant", 32'(req_ready), 32'(1) << g);
    exp_p = ref_mul(op_a[g], op_b[g]);
    rsp_ready = (stall == 0);
    @(posedge clk);
    #1;
    rr_model = (g + 1) % N;
    if (keep) begin
      op_a[g] = W'($urandom);
      op_b[g] = W'($urandom);
      pack_ops();
    end else begin
      req_valid[g] = 1'b0;
    end
    lat = 0;
    bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready != '0 || !busy) bad = 1'b1;
    end while (!rsp_valid && lat < 4 * W);
    check_eq("latency", 32'(lat), 32'(W + 1));
    check_eq("busy_no_grant", 32'(bad), 32'(0));
    prod = rsp_product;
    check_eq("product", 32'(rsp_product), 32'(exp_p));
    check_eq("rsp_id", 32'(rsp_id), 32'(g));
    bad = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_product !== prod || rsp_id !== IDW'(g) || req_ready != '0)
        bad = 1'b1;
    end
    if (stall > 0) check_eq("stall_hold", 32'(bad), 32'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("consumed", 32'({rsp_valid, busy}), 32'(0));
    rsp_ready = 1'b0;
  endtask

  int              g;
  int              grants [3];
  logic [2*W-1:0]  p;
  int              ext_a [4] = '{-8, -8, 7, 0};
  int              ext_b [4] = '{-8, 7, 7, -5};
  logic [2*W-1:0]  ext_p [4] = '{8'h40, 8'hC8, 8'h31, 8'h00};
  bit              active [N];
  int              next_pair;
  bit              any;

  initial begin
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    pack_ops();

    // Reset with both requesters asking: every output must read zero.
    #1 rst_n = 1'b0;
    req_valid = '1;
    #2;
    check_eq("rst_ready", 32'(req_ready), 32'(0));
    check_eq("rst_valid", 32'(rsp_valid), 32'(0));
    check_eq("rst_product", 32'(rsp_product), 32'(0));
    check_eq("rst_id", 32'(rsp_id), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    rr_model = 0;

    // Single op, result consumed in the cycle DONE is entered.
    op_a[0] = W'(3);
    op_b[0] = W'(-2);
    req_valid = 2'b01;
    run_op(0, 1'b0, g, p);
    check_eq("single_const", 32'(p), 32'(8'hFA));

    // Operand extremes, alternating requesters.
    for (int i = 0; i < 4; i++) begin
      op_a[i % N] = W'(ext_a[i]);
      op_b[i % N] = W'(ext_b[i]);
      req_valid = '0;
      req_valid[i % N] = 1'b1;
      run_op(i % 2, 1'b0, g, p);
      check_eq("extreme_const", 32'(p), 32'(ext_p[i]));
    end

    // Backpressure: 10 stalled cycles in DONE.
    op_a[1] = W'(-5);
    op_b[1] = W'(3);
    req_valid = 2'b10;
    run_op(10, 1'b0, g, p);

    // Reset in the second RUN cycle.
    op_a[0] = W'(5);
    op_b[0] = W'(-3);
    req_valid = 2'b01;
    pack_ops();
    @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk);
    check_eq("run_busy", 32'(busy), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ready", 32'(req_ready), 32'(0));
    check_eq("abort_valid", 32'(rsp_valid), 32'(0));
    check_eq("abort_product", 32'(rsp_product), 32'(0));
    check_eq("abort_id", 32'(rsp_id), 32'(0));
    check_eq("abort_busy", 32'(busy), 32'(0));
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    rr_model = 0;
    op_a[1] = W'(-7);
    op_b[1] = W'(6);
    req_valid = 2'b10;
    run_op(0, 1'b0, g, p);
    check_eq("post_abort_const", 32'(p), 32'(8'hD6));

    // Contention: rr_ptr is 0 again, both valid continuously.
    for (int i = 0; i < N; i++) begin
      op_a[i] = W'($urandom);
      op_b[i] = W'($urandom);
    end
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      run_op(0, 1'b1, g, p);
      grants[k] = g;
    end
    req_valid = '0;
    check_eq("rr_order0", 32'(grants[0]), 32'(0));
    check_eq("rr_order1", 32'(grants[1]), 32'(1));
    check_eq("rr_order2", 32'(grants[2]), 32'(0));

    // All 256 operand pairs from random requesters with random backpressure.
    next_pair = 0;
    for (int i = 0; i < N; i++) active[i] = 1'b0;
    do begin
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!active[i] && next_pair < 256 && $urandom_range(0, 1) == 1) begin
          op_a[i] = W'(next_pair >> 4);
          op_b[i] = W'(next_pair);
          active[i] = 1'b1;
          next_pair++;
        end
        any |= active[i];
      end
      if (!any) begin
        g = $urandom_range(0, N - 1);
        op_a[g] = W'(next_pair >> 4);
        op_b[g] = W'(next_pair);
        active[g] = 1'b1;
        next_pair++;
      end
      for (int i = 0; i < N; i++) req_valid[i] = active[i];
      run_op($urandom_range(0, 2), 1'b0, g, p);
      if (g >= 0) active[g] = 1'b0;
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= active[i];
    end while (next_pair < 256 || any);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
